// File: rtl/change_dispenser_pkg.sv
// Shared types and defaults for the change dispenser: report status codes,
// controller states and the default coin denominations.
package change_pkg;

  typedef enum logic [1:0] {
    OK       = 2'd0,
    EXACT    = 2'd1,
    COUGH_UP = 2'd2,
    SHORT    = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PICK     = 2'd1,
    DISPENSE = 2'd2,
    REPORT   = 2'd3
  } state_t;

  localparam int DEFAULT_NDENOM = 3;
  localparam int DEFAULT_DENOM_VAL [DEFAULT_NDENOM] = '{5, 3, 1};

  // Index width that stays legal even for a single denomination.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin choice: lowest-index (largest) denomination that fits in the
// outstanding amount and still has stock.
module coin_select
  import change_pkg::*;
#(
  parameter int W      = 8,
  parameter int NDENOM = 3,
  parameter int CNTW   = 4,
  parameter int IDXW   = idx_width(NDENOM),
  parameter logic [W-1:0] DENOM_VAL [NDENOM] = '{W'(DEFAULT_DENOM_VAL[0]),
                                                 W'(DEFAULT_DENOM_VAL[1]),
                                                 W'(DEFAULT_DENOM_VAL[2])}
) (
  input  logic [W-1:0]           rem,
  input  logic [NDENOM*CNTW-1:0] counts,
  output logic                   found,
  output logic [IDXW-1:0]        idx
);

  logic [NDENOM-1:0] eligible;

  genvar gi;
  generate
    for (gi = 0; gi < NDENOM; gi++) begin : g_elig
      assign eligible[gi] = (DENOM_VAL[gi] <= rem) &&
                            (counts[gi*CNTW +: CNTW] != '0);
    end
  endgenerate

  // Scan from the smallest coin upward so the largest eligible one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NDENOM - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found = 1'b1;
        idx   = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts cost/paid requests, hands out coins one at a time
// from a refillable per-denomination inventory, then reports the outcome.
module change_dispenser
  import change_pkg::*;
#(
  parameter int W          = 8,
  parameter int NDENOM     = 3,
  parameter logic [W-1:0] DENOM_VAL [NDENOM] = '{W'(DEFAULT_DENOM_VAL[0]),
                                                 W'(DEFAULT_DENOM_VAL[1]),
                                                 W'(DEFAULT_DENOM_VAL[2])},
  parameter int CNTW       = 4,
  parameter int INIT_COUNT = 3,
  parameter int MAX_COINS  = 15,
  localparam int IDXW      = idx_width(NDENOM)
) (
  input  logic                   clock,
  input  logic                   reset_L,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [W-1:0]           cost,
  input  logic [W-1:0]           paid,
  output logic                   coin_valid,
  input  logic                   coin_ready,
  output logic [IDXW-1:0]        coin_idx,
  output logic [W-1:0]           coin_value,
  output logic                   done_valid,
  output logic [1:0]             status,
  output logic [W-1:0]           remaining,
  input  logic                   refill_valid,
  input  logic [IDXW-1:0]        refill_idx,
  input  logic [CNTW-1:0]        refill_count,
  output logic [NDENOM*CNTW-1:0] inventory
);

  localparam int CCW = $clog2(MAX_COINS + 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(INIT_COUNT);

  state_t          state_q, state_d;
  status_t         status_q, status_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    remaining_q, remaining_d;
  logic [CCW-1:0]  coin_cnt_q, coin_cnt_d;
  logic [IDXW-1:0] coin_idx_q, coin_idx_d;
  logic [W-1:0]    coin_value_q, coin_value_d;
  logic [CNTW-1:0] count_q [NDENOM];
  logic [CNTW-1:0] count_d [NDENOM];

  logic            sel_found;
  logic [IDXW-1:0] sel_idx;
  logic            coin_fire;
  logic [W-1:0]    rem_after;
  logic [CCW-1:0]  cnt_after;

  assign coin_fire = (state_q == DISPENSE) && coin_ready;
  assign rem_after = rem_q - coin_value_q;
  assign cnt_after = coin_cnt_q + CCW'(1);

  // Inventory counters: refill and dispense may hit the same slot together.
  genvar gi;
  generate
    for (gi = 0; gi < NDENOM; gi++) begin : g_cnt
      logic          take;
      logic          add;
      logic [CNTW:0] sum;

      assign take = coin_fire && (coin_idx_q == IDXW'(gi));
      assign add  = refill_valid && (refill_idx == IDXW'(gi));

      always_comb begin
        sum = {1'b0, count_q[gi]}
            + (add ? {1'b0, refill_count} : {(CNTW+1){1'b0}})
            - {{CNTW{1'b0}}, take};
        count_d[gi] = sum[CNTW] ? CNT_MAX : sum[CNTW-1:0];
      end

      always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
          count_q[gi] <= CNT_INIT;
        end else begin
          count_q[gi] <= count_d[gi];
        end
      end

      assign inventory[gi*CNTW +: CNTW] = count_q[gi];
    end
  endgenerate

  coin_select #(
    .W         (W),
    .NDENOM    (NDENOM),
    .CNTW      (CNTW),
    .IDXW      (IDXW),
    .DENOM_VAL (DENOM_VAL)
  ) u_coin_select (
    .rem    (rem_q),
    .counts (inventory),
    .found  (sel_found),
    .idx    (sel_idx)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      status_q     <= OK;
      rem_q        <= '0;
      remaining_q  <= '0;
      coin_cnt_q   <= '0;
      coin_idx_q   <= '0;
      coin_value_q <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      rem_q        <= rem_d;
      remaining_q  <= remaining_d;
      coin_cnt_q   <= coin_cnt_d;
      coin_idx_q   <= coin_idx_d;
      coin_value_q <= coin_value_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    rem_d        = rem_q;
    remaining_d  = remaining_q;
    coin_cnt_d   = coin_cnt_q;
    coin_idx_d   = coin_idx_q;
    coin_value_d = coin_value_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          coin_cnt_d = '0;
          if (paid < cost) begin
            state_d     = REPORT;
            status_d    = COUGH_UP;
            remaining_d = cost - paid;
          end else if (paid == cost) begin
            state_d     = REPORT;
            status_d    = (paid != '0) ? EXACT : OK;
            remaining_d = '0;
          end else begin
            rem_d   = paid - cost;
            state_d = PICK;
          end
        end
      end

      PICK: begin
        if (sel_found) begin
          coin_idx_d   = sel_idx;
          coin_value_d = DENOM_VAL[sel_idx];
          state_d      = DISPENSE;
        end else begin
          state_d     = REPORT;
          status_d    = (rem_q == '0) ? OK : SHORT;
          remaining_d = rem_q;
        end
      end

      DISPENSE: begin
        if (coin_ready) begin
          rem_d      = rem_after;
          coin_cnt_d = cnt_after;
          // Coin budget exhausted with value still owed: give up here.
          if ((cnt_after == CCW'(MAX_COINS)) && (rem_after != '0)) begin
            state_d     = REPORT;
            status_d    = SHORT;
            remaining_d = rem_after;
          end else begin
            state_d = PICK;
          end
        end
      end

      REPORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign coin_valid = (state_q == DISPENSE);
  assign done_valid = (state_q == REPORT);
  assign coin_idx   = coin_idx_q;
  assign coin_value = coin_value_q;
  assign status     = status_q;
  assign remaining  = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a table of transactions run back to
// back on one inventory, plus hand-written stall, refill, budget and reset cases.
module tb_change_dispenser;
  import change_pkg::*;

  localparam int W = 8;
  localparam int NDENOM = 3;
  localparam int CNTW = 4;
  localparam int IDXW = 2;

  logic                   clock;
  logic                   reset_L;
  logic                   req_valid;
  logic                   req_ready;
  logic [W-1:0]           cost;
  logic [W-1:0]           paid;
  logic                   coin_valid;
  logic                   coin_ready;
  logic [IDXW-1:0]        coin_idx;
  logic [W-1:0]           coin_value;
  logic                   done_valid;
  logic [1:0]             status;
  logic [W-1:0]           remaining;
  logic                   refill_valid;
  logic [IDXW-1:0]        refill_idx;
  logic [CNTW-1:0]        refill_count;
  logic [NDENOM*CNTW-1:0] inventory;

  change_dispenser dut (
    .clock        (clock),
    .reset_L      (reset_L),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .cost         (cost),
    .paid         (paid),
    .coin_valid   (coin_valid),
    .coin_ready   (coin_ready),
    .coin_idx     (coin_idx),
    .coin_value   (coin_value),
    .done_valid   (done_valid),
    .status       (status),
    .remaining    (remaining),
    .refill_valid (refill_valid),
    .refill_idx   (refill_idx),
    .refill_count (refill_count),
    .inventory    (inventory)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int      cost;
    int      paid;
    int      n;
    int      coins[4];
    status_t st;
    int      rem;
    int      inv[3];
    int      lat;
  } vec_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tbl[9];

  function automatic vec_t mk(int c, int p, int n, int c0, int c1, int c2,
                              status_t st, int rem, int i0, int i1, int i2, int lat);
    vec_t v;
    v.cost = c; v.paid = p; v.n = n;
    v.coins[0] = c0; v.coins[1] = c1; v.coins[2] = c2; v.coins[3] = c2;
    v.st = st; v.rem = rem;
    v.inv[0] = i0; v.inv[1] = i1; v.inv[2] = i2;
    v.lat = lat;
    return v;
  endfunction

  function automatic int value_to_idx(int v);
    if (v == 5) return 0;
    if (v == 3) return 1;
    return 2;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_L = 1'b0;
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
  endtask

  task automatic check_inv(input string tag, input int i0, input int i1, input int i2);
    check({tag, ".inv0"}, int'(inventory[0 +: CNTW]), i0);
    check({tag, ".inv1"}, int'(inventory[CNTW +: CNTW]), i1);
    check({tag, ".inv2"}, int'(inventory[2*CNTW +: CNTW]), i2);
  endtask

  task automatic refill(input int idx, input int cnt);
    @(negedge clock);
    refill_valid = 1'b1;
    refill_idx   = IDXW'(idx);
    refill_count = CNTW'(cnt);
    @(negedge clock);
    refill_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int ncoin;
    int lat_done;
    int ev;
    bit got_done;
    @(negedge clock);
    check({tag, ".req_ready"}, int'(req_ready), 1);
    cost = W'(v.cost); paid = W'(v.paid);
    req_valid = 1'b1; coin_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    ncoin = 0; lat_done = 0; got_done = 1'b0;
    for (int cyc = 1; cyc <= 100 && !got_done; cyc++) begin
      @(negedge clock);
      if (coin_valid) begin
        ev = v.coins[(ncoin < 4) ? ncoin : 3];
        check({tag, ".coin_value"}, int'(coin_value), ev);
        check({tag, ".coin_idx"}, int'(coin_idx), value_to_idx(ev));
        if (ncoin == 0 && v.n > 0 && v.lat == 0 && v.cost == 0 && v.paid == 5)
          check({tag, ".first_coin_lat"}, cyc, 2);
        ncoin++;
      end
      if (done_valid) begin
        got_done = 1'b1;
        lat_done = cyc;
      end
    end
    check({tag, ".done_seen"}, int'(got_done), 1);
    if (v.lat != 0) check({tag, ".done_lat"}, lat_done, v.lat);
    check({tag, ".ncoins"}, ncoin, v.n);
    check({tag, ".status"}, int'(status), int'(v.st));
    check({tag, ".remaining"}, int'(remaining), v.rem);
    check_inv(tag, v.inv[0], v.inv[1], v.inv[2]);
    @(negedge clock);
    check({tag, ".done_pulse"}, int'(done_valid), 0);
    check({tag, ".status_hold"}, int'(status), int'(v.st));
    $display("txn %s cost=%0d paid=%0d coins=%0d status=%0d remaining=%0d",
             tag, v.cost, v.paid, ncoin, status, remaining);
  endtask

  task automatic wait_coin(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (coin_valid) seen = 1'b1;
    end
    check({tag, ".coin_seen"}, int'(seen), 1);
  endtask

  initial begin
    int pulses;
    reset_L = 1'b0; req_valid = 1'b0; cost = '0; paid = '0;
    coin_ready = 1'b0; refill_valid = 1'b0; refill_idx = '0; refill_count = '0;

    tbl[0] = mk(4, 15, 3, 5, 5, 1, OK, 0, 1, 3, 2, 0);
    tbl[1] = mk(9, 9, 0, 0, 0, 0, EXACT, 0, 1, 3, 2, 1);
    tbl[2] = mk(10, 7, 0, 0, 0, 0, COUGH_UP, 3, 1, 3, 2, 1);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, OK, 0, 1, 3, 2, 1);
    tbl[4] = mk(0, 5, 1, 5, 5, 5, OK, 0, 0, 3, 2, 0);
    tbl[5] = mk(0, 6, 2, 3, 3, 3, OK, 0, 0, 1, 2, 0);
    tbl[6] = mk(0, 1, 1, 1, 1, 1, OK, 0, 0, 1, 1, 0);
    tbl[7] = mk(0, 6, 2, 3, 1, 1, SHORT, 2, 0, 0, 0, 0);
    tbl[8] = mk(1, 3, 0, 0, 0, 0, SHORT, 2, 0, 0, 0, 2);

    // Reset state
    repeat (2) @(negedge clock);
    check("rst.req_ready", int'(req_ready), 1);
    check("rst.coin_valid", int'(coin_valid), 0);
    check("rst.done_valid", int'(done_valid), 0);
    check("rst.status", int'(status), int'(OK));
    check("rst.remaining", int'(remaining), 0);
    check("rst.coin_value", int'(coin_value), 0);
    check_inv("rst", 3, 3, 3);
    reset_L = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Stalled coin, then handshake with a same-slot refill
    do_reset();
    @(negedge clock);
    cost = 8'd0; paid = 8'd5; req_valid = 1'b1; coin_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    wait_coin("stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall.coin_valid", int'(coin_valid), 1);
      check("stall.coin_value", int'(coin_value), 5);
      check("stall.coin_idx", int'(coin_idx), 0);
    end
    coin_ready = 1'b1; refill_valid = 1'b1; refill_idx = 2'd0; refill_count = 4'd2;
    @(negedge clock);
    refill_valid = 1'b0;
    check("stall.inv0", int'(inventory[0 +: CNTW]), 4);
    repeat (2) @(negedge clock);
    check("stall.status", int'(status), int'(OK));
    $display("txn stall cost=0 paid=5 inv0=%0d status=%0d", inventory[0 +: CNTW], status);

    // Refill saturation and out-of-range index
    do_reset();
    refill(1, 15);
    refill(3, 5);
    check_inv("sat", 3, 15, 3);
    $display("txn refill inventory=%h", inventory);

    // Coin budget: exhausted with value owed, and exhausted exactly at zero
    do_reset();
    refill(0, 12);
    run_txn(mk(0, 255, 15, 5, 5, 5, SHORT, 180, 0, 3, 3, 0), "max_short");
    do_reset();
    refill(0, 12);
    run_txn(mk(0, 75, 15, 5, 5, 5, OK, 0, 0, 3, 3, 0), "max_exact");

    // Asynchronous reset in the middle of a dispense
    do_reset();
    @(negedge clock);
    cost = 8'd0; paid = 8'd15; req_valid = 1'b1; coin_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    wait_coin("abort");
    #2 reset_L = 1'b0;
    #1;
    check("abort.coin_valid", int'(coin_valid), 0);
    check("abort.done_valid", int'(done_valid), 0);
    check("abort.coin_value", int'(coin_value), 0);
    check("abort.coin_idx", int'(coin_idx), 0);
    check("abort.status", int'(status), int'(OK));
    check("abort.remaining", int'(remaining), 0);
    check_inv("abort", 3, 3, 3);
    @(negedge clock);
    reset_L = 1'b1; coin_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done_valid || coin_valid) pulses++;
    end
    check("abort.pulses", pulses, 0);
    check("abort.req_ready", int'(req_ready), 1);
    $display("txn abort cost=0 paid=15 pulses_after_reset=%0d", pulses);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
